// File: rtl/display_arbiter.sv
// Two-requester round-robin arbiter for a two-digit hex display. Each granted
// value is held for HOLD_CYCLES cycles before the next request is accepted.
module display_arbiter #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       reqAValid,
  input  logic [7:0] reqAData,
  output logic       reqAReady,
  input  logic       reqBValid,
  input  logic [7:0] reqBData,
  output logic       reqBReady,
  input  logic       blank,
  output logic [7:0] hexValue,
  output logic       displayOn,
  output logic       owner,
  output logic       busy
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last;   // 1 = B was granted last
  logic          seen;   // at least one transfer since reset
  logic          win_b;
  logic          xfer;

  // With both valid, B wins only when A was granted last.
  assign win_b = reqBValid & (~reqAValid | ~last);

  always_comb begin
    reqAReady = 1'b0;
    reqBReady = 1'b0;
    state_nxt = state;
    // Readys are gated by reset so nothing looks accepted while held in reset.
    if (resetN && state == IDLE) begin
      reqAReady = reqAValid & ~win_b;
      reqBReady = win_b;
    end
    case (state)
      IDLE:    if (reqAReady || reqBReady) state_nxt = HOLD;
      HOLD:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer = reqAReady | reqBReady;
  assign busy = (state == HOLD);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      hexValue  <= 8'h00;
      owner     <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      seen      <= 1'b0;
      displayOn <= 1'b0;
    end else begin
      state     <= state_nxt;
      displayOn <= (seen | xfer) & ~blank;
      if (xfer) begin
        hexValue <= win_b ? reqBData : reqAData;
        owner    <= win_b;
        last     <= win_b;
        cnt      <= CW'(HOLD_CYCLES - 1);
        seen     <= 1'b1;
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000, SHALL be the minimum number of cycles a granted value stays on the display; legal range >= 1.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 resetN  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 reqAValid  input  1  SHALL indicate requester A is presenting a value.
REQ-005 reqAData  input  8  SHALL be requester A's display value, two hex nibbles.
REQ-006 reqAReady  output  1  SHALL indicate A's value is accepted this cycle.
REQ-007 reqBValid, reqBData, reqBReady SHALL mirror REQ-004..006 for requester B (1, 8, 1 bits).
REQ-008 blank  input  1  SHALL force the display dark without affecting arbitration.
REQ-009 hexValue  output  8  SHALL be the value driven into the two-digit hex-to-7-segment decoder.
REQ-010 displayOn  output  1  SHALL enable the 14-bit segment outputs.
REQ-011 owner  output  1  SHALL identify the source of hexValue (0 = A, 1 = B).
REQ-012 busy  output  1  SHALL be high while a hold period is running.

Function
REQ-013 FSM SHALL have two states: IDLE and HOLD.
REQ-014 In IDLE, a requester SHALL be granted when its valid is high and no other requester wins arbitration, per REQ-015.
REQ-015 Arbitration SHALL be round-robin: with both valid, the requester not granted last SHALL win; with one valid, that requester SHALL win.
REQ-016 reqXReady SHALL be combinational, high only in IDLE for the winner, and never high for both requesters in the same cycle.
REQ-017 A transfer SHALL occur when valid and ready are both high at a rising edge.
REQ-018 On a transfer, at that edge: hexValue <= data, owner <= winner, last-granted <= winner, counter <= HOLD_CYCLES-1, state <= HOLD.
REQ-019 Latency: hexValue SHALL show the new value in the cycle immediately after the handshake cycle.
REQ-020 In HOLD, both readys SHALL be 0, busy SHALL be 1, and counter SHALL decrement by 1 each cycle.
REQ-021 When counter == 0 in HOLD, next state SHALL be IDLE; the counter SHALL never wrap below 0.
REQ-022 HOLD_CYCLES = 1 SHALL give exactly one HOLD cycle.
REQ-023 Each grant under continuous demand SHALL span HOLD_CYCLES+1 cycles (HOLD plus one IDLE handshake cycle).
REQ-024 In IDLE with no valid, hexValue and owner SHALL retain the last granted values.
REQ-025 Requesters SHALL hold valid and data stable until ready; a valid dropped before ready SHALL be ignored, with no transfer.
REQ-026 displayOn SHALL be registered and equal to (at least one transfer since reset) AND NOT blank, delayed one cycle.
REQ-027 blank SHALL NOT stall the counter or alter grants.
REQ-028 The counter width SHALL be clog2(HOLD_CYCLES) bits, minimum 1.

Reset
REQ-029 While resetN = 0: state IDLE, hexValue 0x00, owner 0, busy 0, displayOn 0, counter 0, last-granted = B so that A has first priority.
REQ-030 Reset asserted mid-HOLD SHALL abort the hold immediately and apply REQ-029; no partial transfer SHALL survive.
REQ-031 The first edge after resetN rises SHALL arbitrate normally.

Verification (HOLD_CYCLES = 4 unless stated)
REQ-032 Reset test: drive resetN low with requests active. Expect hexValue 0x00, displayOn 0, busy 0, both readys 0 asynchronously.
REQ-033 Single requester: A valid with 0x3C. Expect reqAReady high in cycle 0, hexValue 0x3C and owner 0 from cycle 1, busy high for cycles 1-4, IDLE in cycle 5.
REQ-034 Contention: A = 0x11 and B = 0x22 both continuously valid from reset. Expect grant order A, B, A, B, with hexValue changing every 5 cycles; readys never both high.
REQ-035 Blank: assert blank during hold of 0x5A. Expect displayOn 0 one cycle later and hexValue still 0x5A; the hold ends on schedule.
REQ-036 Reset mid-hold: apply resetN low in HOLD cycle 2 of B = 0x7E. Expect immediate 0x00 outputs; after release, A wins simultaneous requests.
REQ-037 HOLD_CYCLES = 1: B only valid with 0xF0. Expect a transfer every 2 cycles, busy alternating 1/0, and no counter underflow.
